// File: rtl/team_06_vol_ramp_if.sv
// Bundle between the team_06 control path and the speaker output stage.
// The master drives sample/control inputs; the slave (output stage) returns audio and status.
interface team_06_vol_ramp_if;
    logic       sample_valid;
    logic [7:0] spk_aud;
    logic       vol_en;
    logic       mute_tog;
    logic       vol_up;
    logic       vol_dn;
    logic [7:0] out_aud;
    logic       out_valid;
    logic [3:0] vol_level;
    logic       ramping;

    modport master (
        output sample_valid, spk_aud, vol_en, mute_tog, vol_up, vol_dn,
        input  out_aud, out_valid, vol_level, ramping
    );

    modport slave (
        input  sample_valid, spk_aud, vol_en, mute_tog, vol_up, vol_dn,
        output out_aud, out_valid, vol_level, ramping
    );
endinterface

// File: rtl/team_06_vol_ramp.sv
// Speaker output stage: button-driven volume level with click-free gain slewing per sample.
// Define TEAM_06_VOL_RAMP_EN for the sample-paced ramp; otherwise gain steps to target in one cycle.
module team_06_vol_ramp #(
    parameter int MAX_LEVEL     = 8,
    parameter int DEFAULT_LEVEL = 4,
    parameter int GAIN_FRAC     = 4,
    parameter int RAMP_STEP     = 1
) (
    input logic               clk,
    input logic               rst,
    team_06_vol_ramp_if.slave bus
);
    localparam int MAX_GAIN = MAX_LEVEL << (GAIN_FRAC - 2);
    localparam int GW       = $clog2(MAX_GAIN) + 1;
    localparam int PW       = GW + 10;
    localparam logic [3:0] MAX_LVL = 4'(MAX_LEVEL);
    localparam logic [3:0] DEF_LVL = 4'(DEFAULT_LEVEL);

    typedef enum logic [1:0] {STEADY, UP, DOWN} state_t;

    state_t          state, state_next;
    logic [GW-1:0]   gain, gain_next, target;
    logic [3:0]      level;
    logic [3:0]      up_sr, dn_sr;
    logic            up_edge, dn_edge;

    // Bits [1:0] synchronise the raw buttons; bits [3:2] are prev/prev2 for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_sr <= '0;
            dn_sr <= '0;
        end else begin
            up_sr <= {up_sr[2:0], bus.vol_up};
            dn_sr <= {dn_sr[2:0], bus.vol_dn};
        end
    end

    assign up_edge = up_sr[2] & ~up_sr[3];
    assign dn_edge = dn_sr[2] & ~dn_sr[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= DEF_LVL;
        end else if (up_edge && !dn_edge && level != MAX_LVL) begin
            level <= level + 4'd1;
        end else if (dn_edge && !up_edge && level != 4'd0) begin
            level <= level - 4'd1;
        end
    end

    always_comb begin
        target = '0;
        if (bus.vol_en && !bus.mute_tog) target = GW'(level) << (GAIN_FRAC - 2);
    end

`ifdef TEAM_06_VOL_RAMP_EN
    localparam logic [GW:0] STEP_W = (GW + 1)'(RAMP_STEP);
    logic [GW:0] gain_x, target_x;
    assign gain_x   = {1'b0, gain};
    assign target_x = {1'b0, target};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        gain_next  = gain;
        state_next = STEADY;
        case (state)
            UP: if (bus.sample_valid && gain < target)
                    gain_next = (gain_x + STEP_W >= target_x) ? target : gain + STEP_W[GW-1:0];
            DOWN: if (bus.sample_valid && gain > target)
                    gain_next = (target_x + STEP_W >= gain_x) ? target : gain - STEP_W[GW-1:0];
            default: ;
        endcase
        // Direction follows the live target, so a mid-ramp target change reverses next cycle.
        if (gain_next < target)      state_next = UP;
        else if (gain_next > target) state_next = DOWN;
    end
`else
    always_comb begin
        gain_next  = target;
        state_next = STEADY;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STEADY;
            gain  <= '0;
        end else begin
            state <= state_next;
            gain  <= gain_next;
        end
    end

    assign bus.ramping   = (state != STEADY);
    assign bus.vol_level = level;

    logic signed [8:0]    s;
    logic signed [PW-1:0] p, q, r;
    logic [7:0]           sat;

    // Scaling uses the gain held before this strobe's ramp update.
    always_comb begin
        s   = $signed({1'b0, bus.spk_aud}) - 9'sd128;
        p   = PW'(s) * $signed(PW'({1'b0, gain}));
        q   = p >>> GAIN_FRAC;
        r   = q + $signed(PW'(128));
        sat = r[7:0];
        if (r[PW-1])          sat = 8'd0;
        else if (|r[PW-2:8])  sat = 8'd255;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_aud   <= 8'd128;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.sample_valid;
            if (bus.sample_valid) bus.out_aud <= sat;
        end
    end
endmodule

// File: tb/tb_team_06_vol_ramp.sv
// Directed self-checking bench for team_06_vol_ramp; expectations adapt to TEAM_06_VOL_RAMP_EN.
module tb_team_06_vol_ramp;
`ifdef TEAM_06_VOL_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    team_06_vol_ramp_if bus ();

    team_06_vol_ramp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] got;
    logic       got_valid;

    typedef struct {
        logic [3:0] level;
        logic [7:0] spk;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] v, output logic [7:0] o);
        bus.spk_aud      = v;
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        o         = bus.out_aud;
        got_valid = bus.out_valid;
    endtask

    task automatic press(input bit up, input bit dn);
        bus.vol_up = up;
        bus.vol_dn = dn;
        repeat (4) tick();
        bus.vol_up = 1'b0;
        bus.vol_dn = 1'b0;
        repeat (4) tick();
    endtask

    task automatic settle();
        logic [7:0] o;
        repeat (2) tick();
        for (int n = 0; n < 80 && bus.ramping; n++) strobe(8'd128, o);
        check("settle_timeout", 16'(bus.ramping), 16'd0);
    endtask

    task automatic set_level(input logic [3:0] lvl);
        for (int i = 0; i < 12 && bus.vol_level != lvl; i++) begin
            if (bus.vol_level < lvl) press(1'b1, 1'b0);
            else                     press(1'b0, 1'b1);
        end
        check("set_level", 16'(bus.vol_level), 16'(lvl));
        settle();
    endtask

    initial begin
        vecs[0]  = '{4'd4, 8'd0,   8'd0};
        vecs[1]  = '{4'd4, 8'd255, 8'd255};
        vecs[2]  = '{4'd4, 8'd128, 8'd128};
        vecs[3]  = '{4'd4, 8'd1,   8'd1};
        vecs[4]  = '{4'd4, 8'd127, 8'd127};
        vecs[5]  = '{4'd8, 8'd200, 8'd255};
        vecs[6]  = '{4'd8, 8'd10,  8'd0};
        vecs[7]  = '{4'd8, 8'd132, 8'd136};
        vecs[8]  = '{4'd8, 8'd128, 8'd128};
        vecs[9]  = '{4'd8, 8'd127, 8'd126};
        vecs[10] = '{4'd8, 8'd129, 8'd130};
        vecs[11] = '{4'd1, 8'd200, 8'd146};
        vecs[12] = '{4'd1, 8'd0,   8'd96};
        vecs[13] = '{4'd1, 8'd1,   8'd96};
        vecs[14] = '{4'd1, 8'd255, 8'd159};
        vecs[15] = '{4'd1, 8'd127, 8'd127};
        vecs[16] = '{4'd0, 8'd255, 8'd128};
        vecs[17] = '{4'd0, 8'd0,   8'd128};
        vecs[18] = '{4'd2, 8'd100, 8'd114};

        bus.sample_valid = 1'b0;
        bus.spk_aud      = 8'd128;
        bus.vol_en       = 1'b1;
        bus.mute_tog     = 1'b0;
        bus.vol_up       = 1'b0;
        bus.vol_dn       = 1'b0;
        repeat (3) tick();
        check("rst_out_aud",   16'(bus.out_aud),   16'd128);
        check("rst_out_valid", 16'(bus.out_valid), 16'd0);
        check("rst_vol_level", 16'(bus.vol_level), 16'd4);
        check("rst_ramping",   16'(bus.ramping),   16'd0);
        rst = 1'b0;
        repeat (3) tick();

        // Power-up ramp to unity with a steady 200 input.
        check("pwrup_ramping", 16'(bus.ramping), 16'(RAMP));
        for (int k = 1; k <= 20; k++) begin
            strobe(8'd200, got);
            if (k == 1)  check("pwrup_first", 16'(got), RAMP ? 16'd128 : 16'd200);
            if (k == 9)  check("pwrup_gain8", 16'(got), RAMP ? 16'd164 : 16'd200);
            if (k >= 17) check("pwrup_unity", 16'(got), 16'd200);
        end
        tick();
        check("pwrup_ramp_done", 16'(bus.ramping), 16'd0);

        // Single strobe latency and one-cycle valid.
        strobe(8'd50, got);
        check("lat_out_aud",   16'(got),       16'd50);
        check("lat_out_valid", 16'(got_valid), 16'd1);
        tick();
        check("lat_valid_drop", 16'(bus.out_valid), 16'd0);
        check("lat_hold",       16'(bus.out_aud),   16'd50);

        for (int i = 0; i < 19; i++) begin
            if (bus.vol_level != vecs[i].level) set_level(vecs[i].level);
            strobe(vecs[i].spk, got);
            check($sformatf("vec%0d", i), 16'(got), 16'(vecs[i].exp_out));
        end

        // Level saturation and button corner cases.
        set_level(4'd4);
        press(1'b1, 1'b1);
        check("simul_edges", 16'(bus.vol_level), 16'd4);
        for (int i = 1; i <= 5; i++) begin
            press(1'b0, 1'b1);
            check("dn_press", 16'(bus.vol_level), 16'(i >= 4 ? 0 : 4 - i));
        end
        set_level(4'd4);
        for (int i = 1; i <= 5; i++) begin
            press(1'b1, 1'b0);
            check("up_press", 16'(bus.vol_level), 16'(i >= 4 ? 8 : 4 + i));
        end
        set_level(4'd4);

        // Mute ramp down, reversal mid-ramp, then full decay.
        bus.mute_tog = 1'b1;
        tick();
        for (int j = 1; j <= 8; j++) begin
            strobe(8'd200, got);
            if (j == 1) check("mute_first", 16'(got), RAMP ? 16'd200 : 16'd128);
            if (j == 8) check("mute_gain9", 16'(got), RAMP ? 16'd168 : 16'd128);
        end
        bus.mute_tog = 1'b0;
        tick();
        check("unmute_ramping", 16'(bus.ramping), 16'(RAMP));
        strobe(8'd200, got);
        check("reverse_gain8", 16'(got), RAMP ? 16'd164 : 16'd200);
        strobe(8'd200, got);
        check("reverse_gain9", 16'(got), RAMP ? 16'd168 : 16'd200);
        bus.mute_tog = 1'b1;
        tick();
        for (int j = 1; j <= 11; j++) strobe(8'd200, got);
        check("mute_silent", 16'(got), 16'd128);
        tick();
        check("mute_ramp_done", 16'(bus.ramping), 16'd0);
        bus.mute_tog = 1'b0;

        // Reset in the middle of a ramp towards level 6.
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("pre_rst_level", 16'(bus.vol_level), 16'd6);
        for (int j = 0; j < 3; j++) strobe(8'd200, got);
        check("pre_rst_ramping", 16'(bus.ramping), 16'(RAMP));
        rst = 1'b1;
        #2;
        check("midrst_out_aud",   16'(bus.out_aud),   16'd128);
        check("midrst_vol_level", 16'(bus.vol_level), 16'd4);
        check("midrst_ramping",   16'(bus.ramping),   16'd0);
        check("midrst_valid",     16'(bus.out_valid), 16'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
